// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states, datapath mux selects.
// Latency: none (declarations and one combinational helper only).
// Backpressure: not applicable. Build option: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN adds the S_TRAP state.
package riscv_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        ,
        S_TRAP     = 4'd11
`endif
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    // Coarse ALU request from the FSM; the decoder refines ALUOP_FUNCT.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_MEMDATA   = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    // Extender select depends only on the opcode, so it is valid in every state.
    function automatic imm_src_t imm_src_of(input logic [6:0] op);
        imm_src_t sel;
        sel = IMM_I;
        case (op)
            OP_SW:   sel = IMM_S;
            OP_BEQ:  sel = IMM_B;
            OP_JAL:  sel = IMM_J;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields onto the ALU operation select.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Only R-type (op[5]=1) may select sub; addi with a set imm bit 10 stays add.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing a shared RV32I datapath through fetch/decode/execute/mem/writeback.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles, plus one per cycle mem_ready is low in FETCH/MEMREAD/MEMWRITE.
// Backpressure: mem_ready low holds the FSM in its memory state; MULTICYCLE_CTRL_ILLEGAL_TRAP_EN traps unknown ops.
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       srst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal_instr
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;

    // Raw enables before the reset gate.
    logic       mem_req_raw;
    logic       pc_write_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;

    // State register.
    always_ff @(posedge clk) begin
        if (srst) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        next_state    = state;
        mem_req_raw   = 1'b0;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;
        alu_op        = ALUOP_ADD;

        case (state)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                alu_src_a    = SRCA_PC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                next_state   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes the branch target from OldPC + imm.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECUTER;
                    OP_I:         next_state = S_EXECUTEI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                    default:      next_state = S_TRAP;
`else
                    default:      next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_IMM;
                next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
                result_src  = RES_ALUOUT;
                next_state  = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src    = RES_MEMDATA;
                reg_write_raw = 1'b1;
                next_state    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                adr_src       = 1'b1;
                result_src    = RES_ALUOUT;
                mem_write_raw = 1'b1;
                next_state    = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write_raw = 1'b1;
                next_state    = S_FETCH;
            end
            S_BEQ: begin
                // ALUOut holds the target from DECODE; take it only when rs1 == rs2.
                alu_src_a    = SRCA_RD1;
                alu_src_b    = SRCB_RD2;
                alu_op       = ALUOP_SUB;
                result_src   = RES_ALUOUT;
                pc_write_raw = zero;
                next_state   = S_FETCH;
            end
            S_JAL: begin
                // Redirect PC to the target while computing the link value OldPC + 4.
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALUOUT;
                pc_write_raw = 1'b1;
                next_state   = S_ALUWB;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                next_state = S_TRAP;
            end
`endif
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // Reset blocks every side effect in the same cycle it is asserted.
    always_comb begin
        mem_req   = mem_req_raw   & ~srst;
        pc_write  = pc_write_raw  & ~srst;
        mem_write = mem_write_raw & ~srst;
        ir_write  = ir_write_raw  & ~srst;
        reg_write = reg_write_raw & ~srst;
        imm_src   = imm_src_of(op);
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky flag, set on the way into TRAP and cleared only by reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            illegal_q <= 1'b0;
        end else if (next_state == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       srst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BAD = 7'b1111111;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .srst(srst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write),
        .illegal_instr(illegal_instr)
    );

    // Observed vector: req pcw adr mw irw res[2] a[2] b[2] alu[3] imm[2] rw ill
    wire [17:0] obs = {mem_req, pc_write, adr_src, mem_write, ir_write, result_src,
                       alu_src_a, alu_src_b, alu_control, imm_src, reg_write, illegal_instr};

    // Pending cycle script: phase name, mem_ready, srst for each cycle.
    string ph_q[$];
    logic  mr_q[$];
    logic  rst_q[$];

    function automatic logic [1:0] imm_model(input logic [6:0] o);
        if (o == T_SW)  return 2'b01;
        if (o == T_BEQ) return 2'b10;
        if (o == T_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] funct_model(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == T_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs for one cycle, straight from the per-phase output table.
    function automatic logic [17:0] exp_vec(input string ph, input logic [6:0] o, input logic [2:0] f3,
                                            input logic f7, input logic z, input logic mr, input logic rst);
        logic req, pcw, adr, mw, irw, rw, ill;
        logic [1:0] res, a, b;
        logic [2:0] alu;
        {req, pcw, adr, mw, irw, rw, ill} = 7'b0;
        res = 2'b00; a = 2'b00; b = 2'b00; alu = 3'b000;
        case (ph)
            "FETCH":    begin req = 1; b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            "DECODE":   begin a = 2'b01; b = 2'b01; end
            "MEMADR":   begin a = 2'b10; b = 2'b01; end
            "MEMREAD":  begin req = 1; adr = 1; end
            "MEMWB":    begin res = 2'b01; rw = 1; end
            "MEMWRITE": begin req = 1; adr = 1; mw = 1; end
            "EXECR":    begin a = 2'b10; b = 2'b00; alu = funct_model(o, f3, f7); end
            "EXECI":    begin a = 2'b10; b = 2'b01; alu = funct_model(o, f3, f7); end
            "ALUWB":    begin rw = 1; end
            "BEQ":      begin a = 2'b10; alu = 3'b001; pcw = z; end
            "JAL":      begin a = 2'b01; b = 2'b10; pcw = 1; end
            "TRAP":     begin ill = 1; end
            default:    begin end
        endcase
        if (rst) begin req = 0; pcw = 0; irw = 0; mw = 0; rw = 0; end
        return {req, pcw, adr, mw, irw, res, a, b, alu, imm_model(o), rw, ill};
    endfunction

    task automatic push(input string ph, input logic mr, input logic rst);
        ph_q.push_back(ph); mr_q.push_back(mr); rst_q.push_back(rst);
    endtask

    // Replay the script one cycle per entry, checking every output at the falling edge.
    task automatic play(input string name);
        logic [17:0] e;
        int n = 0;
        while (ph_q.size() > 0) begin
            string ph = ph_q.pop_front();
            logic  mr = mr_q.pop_front();
            logic  rs = rst_q.pop_front();
            mem_ready = mr;
            srst      = rs;
            n++;
            @(negedge clk);
            e = exp_vec(ph, op, funct3, funct7b5, zero, mr, rs);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s c%0d %s: got %b want %b", name, n, ph, obs, e);
            end
            @(posedge clk); #1;
        end
        srst = 1'b0;
    endtask

    // Script one instruction from FETCH back to (but not including) the next FETCH.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fs, input int ms);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        repeat (fs) push("FETCH", 1'b0, 1'b0);
        push("FETCH", 1'b1, 1'b0);
        push("DECODE", 1'($urandom), 1'b0);
        case (o)
            T_LW: begin
                push("MEMADR", 1'($urandom), 1'b0);
                repeat (ms) push("MEMREAD", 1'b0, 1'b0);
                push("MEMREAD", 1'b1, 1'b0);
                push("MEMWB", 1'($urandom), 1'b0);
            end
            T_SW: begin
                push("MEMADR", 1'($urandom), 1'b0);
                repeat (ms) push("MEMWRITE", 1'b0, 1'b0);
                push("MEMWRITE", 1'b1, 1'b0);
            end
            T_R:   begin push("EXECR", 1'($urandom), 1'b0); push("ALUWB", 1'($urandom), 1'b0); end
            T_I:   begin push("EXECI", 1'($urandom), 1'b0); push("ALUWB", 1'($urandom), 1'b0); end
            T_BEQ: push("BEQ", 1'($urandom), 1'b0);
            T_JAL: begin push("JAL", 1'($urandom), 1'b0); push("ALUWB", 1'($urandom), 1'b0); end
            default: begin end
        endcase
        play(name);
    endtask

    task automatic test_reset();
        srst = 1'b1; mem_ready = 1'b1; op = T_LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        push("FETCH", 1'b1, 1'b1);
        push("FETCH", 1'b1, 1'b1);
        push("FETCH", 1'b0, 1'b0);
        play("reset");
    endtask

    task automatic test_lw();
        run_instr("lw", T_LW, 3'b010, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_rtype_sub();
        run_instr("r_sub", T_R, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("addi_b10", T_I, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("r_or", T_R, 3'b110, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", T_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr("beq_not", T_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("jal", T_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_fetch_stall();
        run_instr("fetch_stall", T_I, 3'b111, 1'b0, 1'b0, 3, 0);
        run_instr("mem_stall", T_LW, 3'b010, 1'b0, 1'b0, 0, 2);
    endtask

    task automatic test_sw_reset();
        op = T_SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
        push("FETCH", 1'b1, 1'b0);
        push("DECODE", 1'b1, 1'b0);
        push("MEMADR", 1'b1, 1'b0);
        push("MEMWRITE", 1'b0, 1'b0);
        push("MEMWRITE", 1'b0, 1'b1);
        play("sw_rst");
        run_instr("after_rst", T_R, 3'b010, 1'b0, 1'b0, 2, 0);
    endtask

    task automatic test_illegal();
        op = T_BAD; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        push("FETCH", 1'b1, 1'b0);
        push("DECODE", 1'b1, 1'b0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        repeat (4) push("TRAP", 1'($urandom), 1'b0);
        push("TRAP", 1'b1, 1'b1);
        play("illegal_trap");
        run_instr("after_trap", T_SW, 3'b010, 1'b0, 1'b0, 1, 0);
`else
        push("FETCH", 1'b0, 1'b0);
        play("illegal_nop");
        run_instr("after_nop", T_SW, 3'b010, 1'b0, 1'b0, 0, 0);
`endif
    endtask

    task automatic test_random();
        logic [6:0] ops [7];
        int nops;
        ops[0] = T_LW; ops[1] = T_SW; ops[2] = T_R; ops[3] = T_I;
        ops[4] = T_BEQ; ops[5] = T_JAL; ops[6] = T_BAD;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        nops = 6;
`else
        nops = 7;
`endif
        for (int i = 0; i < 200; i++) begin
            run_instr($sformatf("rnd%0d", i), ops[$urandom_range(nops - 1, 0)],
                      3'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(2, 0), $urandom_range(2, 0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_rtype_sub();
        test_beq();
        test_fetch_stall();
        test_sw_reset();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
